nts_dispatcher_front: RTL and testbench
=======================================

// Module: nts_dispatcher_front
// PURPOSE
//  Receive-side front end of the NTS packet dispatcher. Captures 64-bit MAC RX
//  words into a double-buffered (ping-pong) frame RAM and commits only good frames.
//  On request, hands the oldest committed frame to the dispatcher read port.
//  Sits between the Ethernet MAC RX interface and the NTS dispatcher/engines.
// PARAMETERS
//  ADDR_WIDTH  default 10  word-address width; each bank holds 2**ADDR_WIDTH 64-bit words
// PORTS
//  i_clk                        in   1           system clock, all logic on rising edge
//  i_areset                     in   1           reset, synchronous, active-high
//  i_rx_data_valid              in   8           byte-valid mask of i_rx_data; 0 = no word
//  i_rx_data                    in   64          RX word, byte 0 in [63:56]
//  i_rx_bad_frame               in   1           current frame ends and is bad (discard)
//  i_rx_good_frame              in   1           current frame ends and is good (commit)
//  i_process_frame              in   1           1-cycle pulse: release dispatch bank, load next committed frame
//  o_dispatch_packet_available  out  1           dispatch bank holds a frame
//  o_dispatch_counter           out  ADDR_WIDTH  word address of last word of dispatched frame
//  o_dispatch_data_valid        out  8           byte-valid mask of that last word
//  i_dispatch_raddr             in   ADDR_WIDTH  dispatch-bank read address
//  o_dispatch_rdata             out  64          dispatch-bank word at i_dispatch_raddr
// BEHAVIOUR
//  Reset: all outputs 0; both banks EMPTY; write pointer 0; write bank = bank 0.
//   Reset mid-frame or mid-dispatch drops all state; RAM contents not cleared.
//  Bank states: EMPTY -> WRITING -> FULL -> DISPATCH -> EMPTY.
//  Write side, per edge with i_rx_data_valid != 0:
//   - if the write bank is EMPTY/WRITING: store word at wptr, record mask as
//     last_valid, set last_addr = wptr, wptr++ (bank WRITING).
//   - wptr saturates at 2**ADDR_WIDTH-1. A word beyond that sets an overflow flag;
//     an overflowed frame is discarded at its end, even on good_frame.
//   - good/bad strobes are sampled in the same cycle as the last data word
//     (word stored first).
//  Frame end:
//   - i_rx_good_frame, no overflow, >=1 word: bank -> FULL; latch last_addr and
//     last_valid for that bank; write bank toggles to the other bank.
//   - i_rx_bad_frame, or overflow: discard; wptr=0; bank stays/returns EMPTY.
//   - good and bad strobed together: bad wins.
//  Drop rule: frame start while the write bank is not EMPTY (other bank FULL
//   or DISPATCH and this bank still owned) -> whole frame ignored until its end
//   strobe. No partial overwrite of a committed bank.
//  Dispatch side:
//   - i_process_frame sampled at edge k: current DISPATCH bank -> EMPTY; the
//     oldest FULL bank -> DISPATCH at edge k+1.
//   - o_dispatch_packet_available rises after edge k+1, i.e. visible in the
//     second cycle after the pulse.
//   - o_dispatch_counter / o_dispatch_data_valid show that bank's latched values.
//   - Pulse with no FULL bank: available goes 0; counter/valid -> 0.
//   - Available stays high until the next i_process_frame; then it drops for at
//     least the cycle after edge k.
//  Read port: o_dispatch_rdata registered, 1-cycle latency from i_dispatch_raddr;
//   reads the DISPATCH bank; undefined content when available=0.
//  Simultaneous commit of bank A and process_frame: commit occurs at edge k, so
//   bank A is eligible to become DISPATCH at k+1.
// TESTING
//  T1 reset: pulse i_areset 1 cycle -> available=0, counter=0, data_valid=0.
//  T2 basic: words 0102030405060708, 0000000220202020, 0000000330303030
//     (mask ff), good with 3rd; pulse process next cycle; available=0 the cycle
//     after -> then available=1, counter=2, valid=ff; raddr 0/1/2 -> those words
//     one cycle later.
//  T3 bad frame: 2 words + bad strobe, then process pulse -> available stays 0.
//  T4 partial last word: 2 words, last mask f0, good -> counter=1, valid=f0.
//  T5 ping-pong: commit A, commit B, process -> A dispatched; process -> B
//     dispatched (counter of B); process -> available=0.
//  T6 overflow (ADDR_WIDTH=3): 9 words + good -> discarded; next process gives
//     available=0.

Source files
------------

// File: rtl/nts_dispatcher_front.sv
// rtl/nts_dispatcher_front.sv - RX capture into ping-pong frame RAM with commit/dispatch handoff
// Two banks cycle EMPTY -> WRITING -> FULL -> DISPATCH -> EMPTY; only good, non-overflowed frames commit.
module nts_dispatcher_front #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic [7:0]            i_rx_data_valid,
  input  logic [63:0]           i_rx_data,
  input  logic                  i_rx_bad_frame,
  input  logic                  i_rx_good_frame,
  input  logic                  i_process_frame,
  output logic                  o_dispatch_packet_available,
  output logic [ADDR_WIDTH-1:0] o_dispatch_counter,
  output logic [7:0]            o_dispatch_data_valid,
  input  logic [ADDR_WIDTH-1:0] i_dispatch_raddr,
  output logic [63:0]           o_dispatch_rdata
);

  typedef enum logic [1:0] {B_EMPTY, B_WRITING, B_FULL, B_DISPATCH} bank_state_t;

  bank_state_t           bank_state     [2];
  bank_state_t           bank_state_nxt [2];
  logic [ADDR_WIDTH-1:0] bank_addr      [2];
  logic [7:0]            bank_valid     [2];
  logic [63:0]           mem [0:(2**(ADDR_WIDTH+1))-1];

  logic                  wbank, dbank, oldest;
  logic                  in_frame, dropping, ovf, load_pending;
  logic [ADDR_WIDTH:0]   wcnt;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [7:0]            last_valid;

  logic word, frame_end, drop_now, w_store, ovf_now, commit, load_bank, load_ok;

  always_comb begin
    word      = |i_rx_data_valid;
    frame_end = i_rx_good_frame | i_rx_bad_frame;
    // A frame starting on a bank we still own (FULL/DISPATCH) is swallowed whole.
    drop_now  = dropping | (word & ~in_frame & (bank_state[wbank] != B_EMPTY));
    w_store   = word & ~drop_now & ~wcnt[ADDR_WIDTH];
    ovf_now   = ovf | (word & ~drop_now & wcnt[ADDR_WIDTH]);
    commit    = i_rx_good_frame & ~i_rx_bad_frame & ~ovf_now & ~drop_now &
                ((wcnt != '0) | w_store);
    load_bank = (bank_state[oldest] == B_FULL) ? oldest : ~oldest;
    load_ok   = (bank_state[load_bank] == B_FULL);

    bank_state_nxt[0] = bank_state[0];
    bank_state_nxt[1] = bank_state[1];
    if (w_store)
      bank_state_nxt[wbank] = B_WRITING;
    if (frame_end && !drop_now) begin
      if (commit)
        bank_state_nxt[wbank] = B_FULL;
      else if (bank_state[wbank] == B_WRITING)
        bank_state_nxt[wbank] = B_EMPTY;
    end
    if (i_process_frame && bank_state[dbank] == B_DISPATCH)
      bank_state_nxt[dbank] = B_EMPTY;
    if (load_pending && load_ok)
      bank_state_nxt[load_bank] = B_DISPATCH;
  end

  always_ff @(posedge i_clk) begin
    if (w_store)
      mem[{wbank, wcnt[ADDR_WIDTH-1:0]}] <= i_rx_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      bank_state[0]               <= B_EMPTY;
      bank_state[1]               <= B_EMPTY;
      bank_addr[0]                <= '0;
      bank_addr[1]                <= '0;
      bank_valid[0]               <= '0;
      bank_valid[1]               <= '0;
      wbank                       <= 1'b0;
      dbank                       <= 1'b0;
      oldest                      <= 1'b0;
      in_frame                    <= 1'b0;
      dropping                    <= 1'b0;
      ovf                         <= 1'b0;
      load_pending                <= 1'b0;
      wcnt                        <= '0;
      last_addr                   <= '0;
      last_valid                  <= '0;
      o_dispatch_packet_available <= 1'b0;
      o_dispatch_counter          <= '0;
      o_dispatch_data_valid       <= '0;
      o_dispatch_rdata            <= '0;
    end else begin
      bank_state[0]    <= bank_state_nxt[0];
      bank_state[1]    <= bank_state_nxt[1];
      o_dispatch_rdata <= mem[{dbank, i_dispatch_raddr}];
      load_pending     <= i_process_frame;

      if (w_store) begin
        wcnt       <= wcnt + 1'b1;
        last_addr  <= wcnt[ADDR_WIDTH-1:0];
        last_valid <= i_rx_data_valid;
      end

      if (frame_end) begin
        in_frame <= 1'b0;
        dropping <= 1'b0;
        ovf      <= 1'b0;
        wcnt     <= '0;
      end else begin
        in_frame <= in_frame | word;
        dropping <= drop_now;
        ovf      <= ovf_now;
      end

      if (commit) begin
        bank_addr[wbank]  <= w_store ? wcnt[ADDR_WIDTH-1:0] : last_addr;
        bank_valid[wbank] <= w_store ? i_rx_data_valid : last_valid;
        wbank             <= ~wbank;
        if (bank_state[~wbank] != B_FULL)
          oldest <= wbank;
      end

      if (i_process_frame)
        o_dispatch_packet_available <= 1'b0;

      // Load happens one edge after the pulse so a same-edge commit is eligible.
      if (load_pending) begin
        o_dispatch_packet_available <= load_ok;
        o_dispatch_counter          <= load_ok ? bank_addr[load_bank] : '0;
        o_dispatch_data_valid       <= load_ok ? bank_valid[load_bank] : '0;
        if (load_ok)
          dbank <= load_bank;
      end
    end
  end

endmodule

// File: tb/tb_nts_dispatcher_front.sv
// tb/tb_nts_dispatcher_front.sv - scoreboard bench for nts_dispatcher_front
module tb_nts_dispatcher_front;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          areset;
  logic [7:0]    rx_data_valid;
  logic [63:0]   rx_data;
  logic          rx_bad_frame, rx_good_frame, process_frame;
  logic          available;
  logic [AW-1:0] counter;
  logic [7:0]    data_valid;
  logic [AW-1:0] raddr;
  logic [63:0]   rdata;

  always #5 clk = ~clk;

  nts_dispatcher_front #(.ADDR_WIDTH(AW)) dut (
    .i_clk                       (clk),
    .i_areset                    (areset),
    .i_rx_data_valid             (rx_data_valid),
    .i_rx_data                   (rx_data),
    .i_rx_bad_frame              (rx_bad_frame),
    .i_rx_good_frame             (rx_good_frame),
    .i_process_frame             (process_frame),
    .o_dispatch_packet_available (available),
    .o_dispatch_counter          (counter),
    .o_dispatch_data_valid       (data_valid),
    .i_dispatch_raddr            (raddr),
    .o_dispatch_rdata            (rdata)
  );

  typedef struct packed {
    logic [7:0][63:0] words;
    logic [AW-1:0]    counter;
    logic [7:0]       valid;
  } exp_t;

  exp_t q[$];
  bit   disp_active;
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    q.delete();
    disp_active = 1'b0;
    checks++;
    if ({available, counter, data_valid, rdata} !== '0) begin
      errors++;
      $display("FAIL reset: avail=%0b counter=%0d valid=%h rdata=%h, required all 0",
               available, counter, data_valid, rdata);
    end
  endtask

  task automatic send_frame(input int n, input logic [7:0] last_mask, input bit good,
                            input bit bad, input bit use_preset,
                            input logic [7:0][63:0] preset);
    exp_t e;
    logic [63:0] w;
    bit accept;
    e = '0;
    accept = good && !bad && n >= 1 && n <= 8 && (q.size() + int'(disp_active)) < 2;
    for (int i = 0; i < n; i++) begin
      w = use_preset ? preset[i] : {$urandom, $urandom};
      if (i < 8) e.words[i] = w;
      rx_data       = w;
      rx_data_valid = (i == n - 1) ? last_mask : 8'hff;
      rx_good_frame = (i == n - 1) ? good : 1'b0;
      rx_bad_frame  = (i == n - 1) ? bad : 1'b0;
      tick();
    end
    rx_data_valid = '0;
    rx_good_frame = 1'b0;
    rx_bad_frame  = 1'b0;
    if (accept) begin
      e.counter = AW'(n - 1);
      e.valid   = last_mask;
      q.push_back(e);
    end
  endtask

  task automatic check_dispatch(input string name);
    exp_t e;
    bit has;
    checks++;
    if (available !== 1'b0) begin
      errors++;
      $display("FAIL %s_avail_gap: avail=%0b, required 0", name, available);
    end
    has = q.size() > 0;
    e = '0;
    if (has) e = q.pop_front();
    disp_active = has;
    tick();
    checks++;
    if (available !== has || counter !== e.counter || data_valid !== e.valid) begin
      errors++;
      $display("FAIL %s_dispatch: avail=%0b counter=%0d valid=%h, required avail=%0b counter=%0d valid=%h",
               name, available, counter, data_valid, has, e.counter, e.valid);
    end
    if (has) begin
      for (int j = 0; j <= int'(e.counter); j++) begin
        raddr = AW'(j);
        tick();
        checks++;
        if (rdata !== e.words[j]) begin
          errors++;
          $display("FAIL %s_rdata[%0d]: got %h, required %h", name, j, rdata, e.words[j]);
        end
      end
    end
  endtask

  task automatic do_process(input string name);
    process_frame = 1'b1;
    tick();
    process_frame = 1'b0;
    check_dispatch(name);
  endtask

  task automatic test_basic();
    logic [7:0][63:0] p;
    p = '0;
    p[0] = 64'h0102030405060708;
    p[1] = 64'h0000000220202020;
    p[2] = 64'h0000000330303030;
    send_frame(3, 8'hff, 1'b1, 1'b0, 1'b1, p);
    do_process("basic");
  endtask

  task automatic test_bad_frame();
    send_frame(2, 8'hff, 1'b0, 1'b1, 1'b0, '0);
    do_process("bad_frame");
    send_frame(2, 8'hff, 1'b1, 1'b1, 1'b0, '0);
    do_process("good_and_bad");
  endtask

  task automatic test_partial();
    send_frame(2, 8'hf0, 1'b1, 1'b0, 1'b0, '0);
    do_process("partial");
  endtask

  task automatic test_ping_pong();
    do_process("pp_clear");
    send_frame(3, 8'hff, 1'b1, 1'b0, 1'b0, '0);
    send_frame(2, 8'h0f, 1'b1, 1'b0, 1'b0, '0);
    send_frame(4, 8'hff, 1'b1, 1'b0, 1'b0, '0);
    do_process("pp_a");
    do_process("pp_b");
    do_process("pp_empty");
  endtask

  task automatic test_overflow();
    send_frame(9, 8'hff, 1'b1, 1'b0, 1'b0, '0);
    do_process("overflow");
    send_frame(8, 8'hc0, 1'b1, 1'b0, 1'b0, '0);
    do_process("max_frame");
  endtask

  task automatic test_commit_with_process();
    exp_t e;
    e = '0;
    e.words[0] = {$urandom, $urandom};
    e.words[1] = {$urandom, $urandom};
    e.counter  = AW'(1);
    e.valid    = 8'h3c;
    rx_data = e.words[0];
    rx_data_valid = 8'hff;
    tick();
    rx_data = e.words[1];
    rx_data_valid = 8'h3c;
    rx_good_frame = 1'b1;
    process_frame = 1'b1;
    q.push_back(e);
    tick();
    rx_data_valid = '0;
    rx_good_frame = 1'b0;
    process_frame = 1'b0;
    check_dispatch("commit_with_process");
  endtask

  task automatic test_reset_mid_dispatch();
    send_frame(2, 8'hff, 1'b1, 1'b0, 1'b0, '0);
    test_reset();
    do_process("after_reset");
  endtask

  initial begin
    areset = 1'b0;
    rx_data_valid = '0;
    rx_data = '0;
    rx_bad_frame = 1'b0;
    rx_good_frame = 1'b0;
    process_frame = 1'b0;
    raddr = '0;
    disp_active = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_bad_frame();
    test_partial();
    test_ping_pong();
    test_overflow();
    test_commit_with_process();
    test_reset_mid_dispatch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
